// File: rtl/tnoc_round_robin_mux_pkg.sv
// Shared tnoc helpers: arbitration state type and one-hot select utilities.
// Helpers operate on vectors zero-extended to MAX_ENTRIES bits.
package tnoc_round_robin_mux_pkg;

  localparam int MAX_ENTRIES = 32;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mux_state_t;

  // Index of the set bit of a one-hot vector; zero for an all-zero vector.
  function automatic int unsigned onehot_to_index(input logic [MAX_ENTRIES-1:0] onehot);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < MAX_ENTRIES; i++) begin
      if (onehot[i]) idx = idx | unsigned'(i);
    end
    return idx;
  endfunction

  function automatic logic onehot_mux_bit(input logic [MAX_ENTRIES-1:0] sel,
                                          input logic [MAX_ENTRIES-1:0] data);
    return |(sel & data);
  endfunction

endpackage

// File: rtl/tnoc_round_robin_arbiter.sv
// Round-robin arbiter: priority pointer plus masked/unmasked lowest-bit encode.
// The pointer moves past the held index when that packet is released.
module tnoc_round_robin_arbiter
  import tnoc_round_robin_mux_pkg::*;
#(
  parameter int ENTRIES = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [ENTRIES-1:0] i_request,
  input  logic               i_grant,
  input  logic               i_release,
  input  logic [ENTRIES-1:0] i_held,
  output logic [ENTRIES-1:0] o_winner
);

  localparam int PTR_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  logic [PTR_W-1:0]       ptr;
  logic [PTR_W-1:0]       ptr_next;
  logic [ENTRIES-1:0]     mask;
  logic [ENTRIES-1:0]     masked_req;
  logic [ENTRIES-1:0]     pick_src;
  logic [MAX_ENTRIES-1:0] held_ext;
  int unsigned            held_idx;

  // Requests at or above the pointer win first; otherwise wrap to the lowest request.
  always_comb begin
    mask = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      mask[i] = (i >= int'(ptr));
    end
    masked_req = i_request & mask;
    pick_src   = (masked_req != '0) ? masked_req : i_request;
    o_winner   = i_grant ? (pick_src & (~pick_src + ENTRIES'(1))) : '0;
  end

  always_comb begin
    held_ext                = '0;
    held_ext[ENTRIES-1:0]   = i_held;
    held_idx                = onehot_to_index(held_ext);
    ptr_next                = (held_idx >= unsigned'(ENTRIES - 1)) ? '0 : PTR_W'(held_idx + 1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr <= '0;
    end else if (i_release) begin
      ptr <= ptr_next;
    end
  end

endmodule

// File: rtl/tnoc_round_robin_mux.sv
// Packet-level N-to-1 round-robin mux; grant is locked from first beat to last.
// Payload, last and ready are combinational selects from the registered grant.
module tnoc_round_robin_mux
  import tnoc_round_robin_mux_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               ENTRIES = 8,
  parameter logic [WIDTH-1:0] DEFAULT = '0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [ENTRIES-1:0] i_valid,
  output logic [ENTRIES-1:0] o_ready,
  input  logic [ENTRIES-1:0] i_last,
  input  logic [WIDTH-1:0]   i_value [ENTRIES],
  output logic               o_valid,
  input  logic               i_ready,
  output logic               o_last,
  output logic [WIDTH-1:0]   o_value,
  output logic [ENTRIES-1:0] o_grant
);

  mux_state_t             state;
  mux_state_t             state_next;
  logic [ENTRIES-1:0]     grant;
  logic [ENTRIES-1:0]     grant_next;
  logic [ENTRIES-1:0]     winner;
  logic                   busy;
  logic                   arb_strobe;
  logic                   release_strobe;
  logic [MAX_ENTRIES-1:0] sel_ext;
  logic [MAX_ENTRIES-1:0] valid_ext;
  logic [MAX_ENTRIES-1:0] last_ext;
  logic [MAX_ENTRIES-1:0] col_ext;
  logic [WIDTH-1:0]       value_sel;

  tnoc_round_robin_arbiter #(
    .ENTRIES (ENTRIES)
  ) u_arbiter (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_request (i_valid),
    .i_grant   (arb_strobe),
    .i_release (release_strobe),
    .i_held    (grant),
    .o_winner  (winner)
  );

  always_comb begin
    sel_ext                = '0;
    valid_ext              = '0;
    last_ext               = '0;
    sel_ext[ENTRIES-1:0]   = grant;
    valid_ext[ENTRIES-1:0] = i_valid;
    last_ext[ENTRIES-1:0]  = i_last;
    busy                   = (state == BUSY);
    o_grant                = grant;
    o_valid                = busy & onehot_mux_bit(sel_ext, valid_ext);
    o_last                 = o_valid & onehot_mux_bit(sel_ext, last_ext);
    // Payload is selected bit-column by bit-column through the one-hot mux.
    value_sel              = '0;
    for (int b = 0; b < WIDTH; b++) begin
      col_ext = '0;
      for (int e = 0; e < ENTRIES; e++) begin
        col_ext[e] = i_value[e][b];
      end
      value_sel[b] = onehot_mux_bit(sel_ext, col_ext);
    end
    o_value        = busy ? value_sel : DEFAULT;
    o_ready        = grant & {ENTRIES{i_ready}};
    release_strobe = o_valid & i_ready & o_last;
    arb_strobe     = ~busy & (|i_valid);
  end

  always_comb begin
    state_next = state;
    grant_next = grant;
    case (state)
      IDLE: begin
        if (arb_strobe) begin
          grant_next = winner;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (release_strobe) begin
          grant_next = '0;
          state_next = IDLE;
        end
      end
      default: begin
        grant_next = '0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      grant <= '0;
    end else begin
      state <= state_next;
      grant <= grant_next;
    end
  end

endmodule

// File: tb/tb_tnoc_round_robin_mux.sv
// Bench for tnoc_round_robin_mux: directed scenarios plus random traffic
// against an integer-level owner/pointer model of the arbitration rules.
module tb_tnoc_round_robin_mux;

  localparam int             W   = 8;
  localparam int             N   = 4;
  localparam logic [W-1:0]   DEF = 8'hA5;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   valid;
  logic [N-1:0]   ready_o;
  logic [N-1:0]   last;
  logic [W-1:0]   value [N];
  logic           o_valid;
  logic           rdy;
  logic           o_last;
  logic [W-1:0]   o_value;
  logic [N-1:0]   o_grant;

  always #5 clk = ~clk;

  tnoc_round_robin_mux #(
    .WIDTH   (W),
    .ENTRIES (N),
    .DEFAULT (DEF)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (valid),
    .o_ready (ready_o),
    .i_last  (last),
    .i_value (value),
    .o_valid (o_valid),
    .i_ready (rdy),
    .o_last  (o_last),
    .o_value (o_value),
    .o_grant (o_grant)
  );

  // Source packet generators
  int           src_len [N];
  int           src_beat [N];
  bit           src_active [N];
  logic [W-1:0] src_val [N];
  bit           autorestart;

  // Reference model: owner = -1 when idle
  int owner;
  int ptr;

  int checks;
  int failures;
  int dut_beats;
  int model_beats;

  logic [N-1:0] log_grant [$];
  logic [N-1:0] log_ready [$];
  logic         log_valid [$];
  logic [W-1:0] log_value [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_pkt(input int s, input int len);
    src_active[s] = 1'b1;
    src_len[s]    = len;
    src_beat[s]   = 0;
    src_val[s]    = W'($urandom);
  endtask

  task automatic clear_log();
    log_grant.delete();
    log_ready.delete();
    log_valid.delete();
    log_value.delete();
  endtask

  task automatic drive();
    for (int s = 0; s < N; s++) begin
      valid[s] = src_active[s];
      last[s]  = src_active[s] && (src_beat[s] == src_len[s] - 1);
      value[s] = src_val[s];
    end
  endtask

  task automatic tick();
    logic [N-1:0] eg, er;
    logic         ev, el;
    logic [W-1:0] evl;
    int           acc;
    drive();
    @(negedge clk);
    if (owner < 0) begin
      eg = '0; er = '0; ev = 1'b0; el = 1'b0; evl = DEF;
    end else begin
      eg  = N'(1) << owner;
      ev  = valid[owner];
      el  = ev & last[owner];
      evl = value[owner];
      er  = rdy ? eg : '0;
    end
    check("grant", o_grant, eg);
    check("valid", o_valid, ev);
    check("last", o_last, el);
    check("ready", ready_o, er);
    check("value", o_value, evl);
    log_grant.push_back(o_grant);
    log_ready.push_back(ready_o);
    log_valid.push_back(o_valid);
    log_value.push_back(o_value);
    if (o_valid && rdy) dut_beats++;
    acc = -1;
    if (owner >= 0 && valid[owner] && rdy) begin
      acc = owner;
      model_beats++;
    end
    if (rst) begin
      owner = -1;
      ptr   = 0;
    end else if (owner < 0) begin
      for (int k = 0; k < N; k++) begin
        if (valid[(ptr + k) % N]) begin
          owner = (ptr + k) % N;
          break;
        end
      end
    end else if (acc >= 0 && last[acc]) begin
      ptr   = (owner + 1) % N;
      owner = -1;
    end
    if (acc >= 0) begin
      if (src_beat[acc] == src_len[acc] - 1) begin
        src_active[acc] = 1'b0;
        if (autorestart) start_pkt(acc, 2);
      end else begin
        src_beat[acc]++;
        src_val[acc] = W'($urandom);
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic bit any_active();
    bit a;
    a = 1'b0;
    for (int s = 0; s < N; s++) a |= src_active[s];
    return a;
  endfunction

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (any_active() && n < 200) begin
      tick();
      n++;
    end
    check(tag, any_active(), 0);
  endtask

  initial begin
    checks = 0; failures = 0; dut_beats = 0; model_beats = 0;
    owner = -1; ptr = 0;
    rst = 1'b1; rdy = 1'b1; autorestart = 1'b1;
    for (int s = 0; s < N; s++) src_active[s] = 1'b0;
    for (int s = 0; s < N; s++) start_pkt(s, 2);
    drive();
    @(posedge clk);
    #1;

    // Reset held with every source requesting
    tick();
    tick();
    check("rst_grant", log_grant[1], 0);
    check("rst_valid", log_valid[1], 0);
    check("rst_value", log_value[1], DEF);
    rst = 1'b0;

    // Fairness: 2-beat packets, one bubble each
    clear_log();
    repeat (14) tick();
    check("fair_idle0", log_grant[0], 0);
    check("fair_beat1", log_grant[2], 4'b0001);
    check("fair_bubble", log_grant[3], 0);
    for (int j = 0; j < 5; j++) check("fair_order", log_grant[1 + 3 * j], 32'(N'(1) << (j % N)));
    autorestart = 1'b0;
    drain("drain_fair");

    // Packet lock: source 2 holds 5 beats while source 1 waits
    start_pkt(2, 5);
    tick();
    start_pkt(1, 3);
    clear_log();
    repeat (5) tick();
    for (int i = 0; i < 5; i++) begin
      check("lock_grant", log_grant[i], 4'b0100);
      check("lock_ready1", log_ready[i][1], 0);
    end
    drain("drain_lock");

    // Backpressure mid-packet
    start_pkt(3, 4);
    tick();
    tick();
    rdy = 1'b0;
    clear_log();
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      check("bp_value", log_value[i], src_val[3]);
      check("bp_ready", log_ready[i], 0);
    end
    rdy = 1'b1;
    drain("drain_bp");

    // Wrap with single-beat packets: pointer lands on 3
    start_pkt(2, 1);
    tick();
    tick();
    start_pkt(0, 1);
    start_pkt(3, 1);
    clear_log();
    repeat (4) tick();
    check("wrap_idle", log_grant[0], 0);
    check("wrap_first", log_grant[1], 4'b1000);
    check("wrap_bubble", log_grant[2], 0);
    check("wrap_second", log_grant[3], 4'b0001);

    // Reset during beat 2 of a 4-beat packet
    start_pkt(0, 4);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    src_active[0] = 1'b0;
    start_pkt(1, 2);
    clear_log();
    tick();
    tick();
    check("mrst_grant", log_grant[0], 0);
    check("mrst_valid", log_valid[0], 0);
    check("mrst_value", log_value[0], DEF);
    check("mrst_regrant", log_grant[1], 4'b0010);
    drain("drain_mrst");

    // Random traffic with sporadic backpressure and reset
    repeat (400) begin
      rst = ($urandom_range(99) == 0);
      rdy = ($urandom_range(3) != 0);
      for (int s = 0; s < N; s++) begin
        if (!src_active[s] && $urandom_range(2) == 0) start_pkt(s, $urandom_range(4, 1));
      end
      tick();
      if (rst) begin
        for (int s = 0; s < N; s++) src_active[s] = 1'b0;
      end
    end
    rst = 1'b0;
    rdy = 1'b1;
    drain("drain_rand");
    check("beat_count", dut_beats, model_beats);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
